// File: rtl/pattern_loader_v1_if.sv
// Source-FIFO / destination-FIFO handshake bundle for pattern_loader_v1.
interface pattern_loader_v1_if #(
  parameter int unsigned DATA_W = 256
);
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_rd_en;
  logic              dst_full;
  logic              dst_wr;
  logic [DATA_W-1:0] dst_data;

  modport master (
    input  src_data, src_valid, dst_full,
    output src_rd_en, dst_wr, dst_data
  );

  modport slave (
    output src_data, src_valid, dst_full,
    input  src_rd_en, dst_wr, dst_data
  );
endinterface

// File: rtl/pattern_loader_v1.sv
// Streams num_pat x num_streams words from a FWFT source FIFO to the imager FIFO, framed by
// optional preamble/postamble words. Optional source-underrun watchdog: PATLOAD_SRC_CHECK_EN.
module pattern_loader_v1 #(
  parameter int unsigned       DATA_W     = 256,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       PRE_WORDS  = 1,
  parameter int unsigned       POST_WORDS = 1,
  parameter logic [DATA_W-1:0] PRE_VALUE  = '1,
  parameter logic [DATA_W-1:0] POST_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_pat,
  input  logic [CNT_W-1:0]     num_streams,
  pattern_loader_v1_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pat_idx
`ifdef PATLOAD_SRC_CHECK_EN
  ,
  output logic                 src_underrun
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_STREAM, S_POST, S_DONE} state_t;

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_word_cnt, w_word_cnt;
  logic [CNT_W-1:0]    r_pat_idx, w_pat_idx;
  logic [CNT_W-1:0]    r_num_pat, w_num_pat;
  logic [CNT_W-1:0]    r_num_streams, w_num_streams;
  logic                r_src_rd_en, w_src_rd_en;
  logic                r_dst_wr, w_dst_wr;
  logic [DATA_W-1:0]   r_dst_data, w_dst_data;
  logic                r_done, w_done;
  logic                w_exit;
  logic [CNT_W-1:0]    w_word_inc;

  assign w_word_inc = r_word_cnt + CNT_W'(1);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_word_cnt    <= '0;
      r_pat_idx     <= '0;
      r_num_pat     <= '0;
      r_num_streams <= '0;
      r_src_rd_en   <= 1'b0;
      r_dst_wr      <= 1'b0;
      r_dst_data    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_word_cnt    <= w_word_cnt;
      r_pat_idx     <= w_pat_idx;
      r_num_pat     <= w_num_pat;
      r_num_streams <= w_num_streams;
      r_src_rd_en   <= w_src_rd_en;
      r_dst_wr      <= w_dst_wr;
      r_dst_data    <= w_dst_data;
      r_done        <= w_done;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_word_cnt    = r_word_cnt;
    w_pat_idx     = r_pat_idx;
    w_num_pat     = r_num_pat;
    w_num_streams = r_num_streams;
    w_src_rd_en   = 1'b0;
    w_dst_wr      = 1'b0;
    w_dst_data    = r_dst_data;
    w_done        = 1'b0;
    w_exit        = 1'b0;
    if (abort) begin
      w_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_num_pat     = num_pat;
            w_num_streams = num_streams;
            w_word_cnt    = '0;
            w_pat_idx     = '0;
            if (PRE_WORDS > 0) w_state = S_PRE;
            else               w_state = S_STREAM;
          end
        end
        S_PRE: begin
          if (!bus.dst_full) begin
            w_dst_wr   = 1'b1;
            w_dst_data = PRE_VALUE;
            w_word_cnt = w_word_inc;
            if (w_word_inc == CNT_W'(PRE_WORDS)) begin
              w_word_cnt = '0;
              w_state    = S_STREAM;
            end
          end
        end
        S_STREAM: begin
          // Pattern boundary takes its own edge; zero lengths leave without writing.
          if (r_num_pat == '0 || r_num_streams == '0) begin
            w_exit = 1'b1;
          end else if (r_word_cnt == r_num_streams) begin
            w_word_cnt = '0;
            w_pat_idx  = r_pat_idx + CNT_W'(1);
            if (r_pat_idx == r_num_pat - CNT_W'(1)) w_exit = 1'b1;
          end else if (bus.src_valid && !bus.dst_full && r_word_cnt < r_num_streams) begin
            w_src_rd_en = 1'b1;
            w_dst_wr    = 1'b1;
            w_dst_data  = bus.src_data;
            w_word_cnt  = w_word_inc;
          end
          if (w_exit) begin
            if (POST_WORDS > 0) w_state = S_POST;
            else                w_state = S_DONE;
          end
        end
        S_POST: begin
          if (!bus.dst_full) begin
            w_dst_wr   = 1'b1;
            w_dst_data = POST_VALUE;
            w_word_cnt = w_word_inc;
            if (w_word_inc == CNT_W'(POST_WORDS)) begin
              w_word_cnt = '0;
              w_state    = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_done    = 1'b1;
          w_pat_idx = '0;
          w_state   = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign pat_idx       = r_pat_idx;
  assign bus.src_rd_en = r_src_rd_en;
  assign bus.dst_wr    = r_dst_wr;
  assign bus.dst_data  = r_dst_data;

`ifdef PATLOAD_SRC_CHECK_EN
  logic [7:0] r_wd_cnt;
  logic       r_underrun;

  // Sticky once 256 consecutive starved STREAM edges are seen; cleared by an accepted start.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt   <= '0;
      r_underrun <= 1'b0;
    end else if (!abort && r_state == S_IDLE && start) begin
      r_wd_cnt   <= '0;
      r_underrun <= 1'b0;
    end else if (!abort && r_state == S_STREAM && !bus.src_valid && !bus.dst_full) begin
      if (r_wd_cnt == 8'hFF) r_underrun <= 1'b1;
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign src_underrun = r_underrun;
`endif

endmodule

// File: tb/tb_pattern_loader_v1.sv
// Directed self-checking bench for pattern_loader_v1 (default and zero-framing builds).
module tb_pattern_loader_v1;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst, start, start1, abort;
  logic [CW-1:0] num_pat, num_streams;
  logic          busy, done, busy1, done1;
  logic [CW-1:0] pat_idx, pat_idx1;
  logic          valid_en, full;
`ifdef PATLOAD_SRC_CHECK_EN
  logic          underrun, underrun1;
`endif

  pattern_loader_v1_if #(.DATA_W(DW)) bus0 ();
  pattern_loader_v1_if #(.DATA_W(DW)) bus1 ();

  pattern_loader_v1 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_pat(num_pat), .num_streams(num_streams), .bus(bus0.master),
    .busy(busy), .done(done), .pat_idx(pat_idx)
`ifdef PATLOAD_SRC_CHECK_EN
    , .src_underrun(underrun)
`endif
  );

  pattern_loader_v1 #(.DATA_W(DW), .CNT_W(CW), .PRE_WORDS(0), .POST_WORDS(0)) dut_nf (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .num_pat(num_pat), .num_streams(num_streams), .bus(bus1.master),
    .busy(busy1), .done(done1), .pat_idx(pat_idx1)
`ifdef PATLOAD_SRC_CHECK_EN
    , .src_underrun(underrun1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] src_word(input int unsigned i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i;
    return {8{w}};
  endfunction

  // Source FIFO model (FWFT, pops on posedge) and destination capture.
  logic [DW-1:0] src_mem [0:15];
  logic [DW-1:0] wr_log  [0:255];
  int unsigned rd_cnt = 0, wr_total = 0, done_cnt = 0, wr1_total = 0, viol = 0;
  int unsigned rd_base, wr_base, done_base;
  int unsigned rd_ptr;

  assign rd_ptr         = rd_cnt - rd_base;
  assign bus0.src_data  = src_mem[rd_ptr[3:0]];
  assign bus0.src_valid = valid_en && (rd_ptr < 16);
  assign bus0.dst_full  = full;
  assign bus1.src_data  = '0;
  assign bus1.src_valid = 1'b0;
  assign bus1.dst_full  = 1'b0;

  always @(posedge clk) begin
    if (bus0.dst_wr) begin
      wr_log[wr_total[7:0]] <= bus0.dst_data;
      wr_total <= wr_total + 1;
    end
    if (bus0.src_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus1.dst_wr) wr1_total <= wr1_total + 1;
  end

  always @(negedge clk) begin
    #1;
    if ((bus0.dst_wr || bus0.src_rd_en) && full) viol <= viol + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic mark();
    rd_base   = rd_cnt;
    wr_base   = wr_total;
    done_base = done_cnt;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    logic got;
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk); #1;
      if (done) got = 1'b1;
      k++;
    end
    check({tag, "_done_seen"}, DW'(got), DW'(1));
  endtask

  task automatic wait_wr(input string tag, input int unsigned n);
    int unsigned k;
    k = 0;
    while ((wr_total - wr_base) < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_reach_wr"}, DW'(wr_total - wr_base), DW'(n));
  endtask

  // Expected stream: one all-ones preamble, n_src source words in order, one zero postamble.
  task automatic check_seq(input string tag, input int unsigned n_src);
    logic [DW-1:0] want;
    int unsigned n;
    n = n_src + 2;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_wr_cnt"}, DW'(wr_total - wr_base), DW'(n));
    check({tag, "_rd_cnt"}, DW'(rd_cnt - rd_base), DW'(n_src));
    check({tag, "_done_cnt"}, DW'(done_cnt - done_base), DW'(1));
    check({tag, "_busy_after"}, DW'(busy), DW'(0));
    for (int unsigned i = 0; i < n; i++) begin
      if (i == 0)          want = '1;
      else if (i == n - 1) want = '0;
      else                 want = src_word(i - 1);
      check($sformatf("%s_word%0d", tag, i), wr_log[(wr_base + i) % 256], want);
    end
  endtask

  initial begin
    int unsigned edges;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
    num_pat = '0; num_streams = '0; valid_en = 1'b0; full = 1'b0;
    rd_base = 0; wr_base = 0; done_base = 0;
    for (int unsigned i = 0; i < 16; i++) src_mem[i] = src_word(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_dst_wr", DW'(bus0.dst_wr), DW'(0));
    check("rst_rd_en", DW'(bus0.src_rd_en), DW'(0));
    check("rst_dst_data", bus0.dst_data, '0);
    check("rst_pat_idx", DW'(pat_idx), DW'(0));
`ifdef PATLOAD_SRC_CHECK_EN
    check("rst_underrun", DW'(underrun), DW'(0));
`endif
    rst = 1'b0;

    // Basic sequence
    num_pat = 2; num_streams = 4; valid_en = 1'b1; full = 1'b0;
    mark(); pulse_start();
    wait_done("basic");
    check("basic_pat_idx_end", DW'(pat_idx), DW'(0));
    check_seq("basic", 8);

    // Source stall for 5 cycles after two stream words
    mark(); pulse_start();
    wait_wr("sstall", 3);
    valid_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("sstall_wr_hold", DW'(wr_total - wr_base), DW'(3));
    check("sstall_rd_hold", DW'(rd_cnt - rd_base), DW'(2));
    check("sstall_busy", DW'(busy), DW'(1));
    valid_en = 1'b1;
    wait_done("sstall");
    check_seq("sstall", 8);

    // Destination stall during PRE and mid-STREAM
    mark(); full = 1'b1; pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check("dstall_pre_wr", DW'(wr_total - wr_base), DW'(0));
    check("dstall_busy", DW'(busy), DW'(1));
    full = 1'b0;
    wait_wr("dstall", 4);
    full = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("dstall_mid_wr", DW'(wr_total - wr_base), DW'(4));
    check("dstall_mid_rd", DW'(rd_cnt - rd_base), DW'(3));
    full = 1'b0;
    wait_done("dstall");
    check_seq("dstall", 8);
    check("dstall_strobe_while_full", DW'(viol), DW'(0));

    // Zero lengths
    num_pat = 0; num_streams = 4;
    mark(); pulse_start();
    wait_done("zpat");
    check_seq("zpat", 0);
    num_pat = 2; num_streams = 0;
    mark(); pulse_start();
    wait_done("zstr");
    check_seq("zstr", 0);

    // No framing words: done three edges after start, nothing written
    num_pat = 0; num_streams = 4;
    @(posedge clk); #1 start1 = 1'b1;
    edges = 0;
    while (!done1 && edges < 10) begin
      @(negedge clk); #1;
      start1 = 1'b0;
      edges++;
    end
    check("nf_done_edges", DW'(edges), DW'(3));
    check("nf_busy", DW'(busy1), DW'(0));
    check("nf_no_writes", DW'(wr1_total), DW'(0));

    // Abort on the third written word, then a clean restart
    num_pat = 2; num_streams = 4;
    mark(); pulse_start();
    wait_wr("abort", 3);
    abort = 1'b1;
    @(negedge clk); #1;
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_dst_wr", DW'(bus0.dst_wr), DW'(0));
    check("abort_rd_en", DW'(bus0.src_rd_en), DW'(0));
    check("abort_data_hold", bus0.dst_data, src_word(1));
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_wr_total", DW'(wr_total - wr_base), DW'(3));
    check("abort_no_done", DW'(done_cnt - done_base), DW'(0));
    mark(); pulse_start();
    wait_done("restart");
    check_seq("restart", 8);

    // Asynchronous reset in the second pattern
    mark(); pulse_start();
    wait_wr("arst", 7);
    check("arst_pat_idx", DW'(pat_idx), DW'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_dst_wr", DW'(bus0.dst_wr), DW'(0));
    check("arst_rd_en", DW'(bus0.src_rd_en), DW'(0));
    check("arst_dst_data", bus0.dst_data, '0);
    check("arst_pat_idx0", DW'(pat_idx), DW'(0));
    @(posedge clk); #1 rst = 1'b0;

`ifdef PATLOAD_SRC_CHECK_EN
    // Starved source for well over 256 STREAM edges
    num_pat = 1; num_streams = 4; valid_en = 1'b0;
    mark(); pulse_start();
    repeat (248) begin @(negedge clk); #1; end
    check("urun_early", DW'(underrun), DW'(0));
    repeat (20) begin @(negedge clk); #1; end
    check("urun_set", DW'(underrun), DW'(1));
    valid_en = 1'b1;
    wait_done("urun");
    check("urun_sticky", DW'(underrun), DW'(1));
    mark(); pulse_start();
    check("urun_clear", DW'(underrun), DW'(0));
    wait_done("urun2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pattern_loader_v1.md
Name: pattern_loader_v1

Overview:
- Parametrised successor to the single-mode pattern loader.
- Moves NUM_PAT patterns of NUM_STREAMS words each from the source pattern FIFO into the imager output FIFO.
- Can wrap the pattern burst with configurable preamble and postamble words.
- Stalls correctly on source-empty or destination-full. It never ends a pattern early.
- Sits between the pattern/camera FIFO and the imager-side FIFO in the exposure pipeline.

Parameters:
- DATA_W, 256, word width of source and destination data.
- CNT_W, 32, width of the stream and pattern counters and of the run-time length inputs.
- PRE_WORDS, 1, number of preamble words written before the first pattern (0 = none).
- POST_WORDS, 1, number of postamble words written after the last pattern (0 = none).
- PRE_VALUE, all ones, preamble word value (DATA_W bits).
- POST_VALUE, 0, postamble word value (DATA_W bits).

Ports:
- clk  in  1  system clock; all logic is updated on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- num_pat  in  CNT_W  patterns per sequence; latched at start.
- num_streams  in  CNT_W  words per pattern; latched at start.
- src_data  in  DATA_W  source FIFO read data (first-word-fall-through).
- src_valid  in  1  src_data is valid.
- src_rd_en  out  1  pops the source FIFO.
- dst_full  in  1  destination FIFO is full.
- dst_wr  out  1  destination write strobe.
- dst_data  out  DATA_W  destination write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes.
- pat_idx  out  CNT_W  index of the pattern currently being streamed.

Behaviour:
- Reset values (async): state = IDLE; src_rd_en = 0; dst_wr = 0; dst_data = 0; done = 0; all counters = 0; pat_idx = 0.
- Registers update on negedge clk. Logic is sensitive to negedge clk or posedge rst.
- src_rd_en, dst_wr and done default to 0 every cycle.
- IDLE:
  - On start, latch num_pat and num_streams and clear the counters.
  - Next state is PRE if PRE_WORDS > 0, else STREAM.
- PRE: each cycle with !dst_full, set dst_wr = 1, dst_data = PRE_VALUE, word_cnt++. After PRE_WORDS writes, clear word_cnt and go to STREAM.
- STREAM:
  - A transfer happens when src_valid && !dst_full && word_cnt < num_streams.
  - On a transfer, in the same edge: src_rd_en = 1, dst_wr = 1, dst_data = src_data, word_cnt++. Latency from source word to dst_wr is one edge.
  - If src_valid = 0 or dst_full = 1: hold. No strobes, counters unchanged.
  - When word_cnt == num_streams: clear word_cnt and increment pat_idx.
  - If pat_idx == num_pat-1 at that point, go to POST if POST_WORDS > 0, else DONE.
  - The check is done on the latched count, one idle edge per pattern boundary.
- num_pat == 0 or num_streams == 0: STREAM writes nothing and exits on the first edge.
- POST: mirrors PRE, using POST_VALUE and POST_WORDS.
- DONE: pulse done for one cycle, clear pat_idx, return to IDLE.
- abort: takes priority over all other events, including a simultaneous transfer. All strobes are 0 on that edge, the next state is IDLE, done is not pulsed, and dst_data holds its value.
- start while busy is ignored.
- Counters compare with full CNT_W-bit unsigned arithmetic. There is no wrap within a legal sequence.
- dst_data holds its last written value between writes.

Optional Feature:
- Macro PATLOAD_SRC_CHECK_EN.
- With the macro defined:
  - Add output port src_underrun (1 bit, reset 0).
  - src_underrun is a sticky flag, set when the block is in STREAM with !src_valid && !dst_full for 256 consecutive cycles.
  - It clears on start.
  - Stalling behaviour is otherwise unchanged.
- Without the macro: the port and the watchdog counter do not exist.

Test Plan:
- Basic sequence: num_pat=2, num_streams=4, PRE/POST=1, src_valid=1, dst_full=0 -> exactly 10 dst_wr in order (0xFF..FF, 8 source words, 0x00..0), 8 src_rd_en, done one pulse, busy low after.
- Source stall: src_valid dropped for 5 cycles mid-pattern -> no dst_wr or src_rd_en during the gap, still exactly 4 words per pattern, no early termination.
- Destination stall: dst_full high during PRE and mid-STREAM -> writes pause and resume with no duplicated or dropped words, and src_rd_en never asserts while dst_full.
- Zero lengths: num_pat=0 -> only the preamble and postamble words are written, then done. With PRE_WORDS=POST_WORDS=0 -> done follows start within 3 edges with no writes.
- Abort and reset: abort on the 3rd word -> IDLE next edge, no done, a following start runs a full clean sequence. rst asserted mid-STREAM -> all outputs 0 immediately, without waiting for a clock edge.
- With PATLOAD_SRC_CHECK_EN defined: hold src_valid=0 for 256 cycles in STREAM -> src_underrun=1 and it stays set; the next start clears it.
